exp7_mostra_sequencia: RTL and testbench

Playback sequencer for the memory game. On a start pulse it walks the jogadas memory from address 0 up to the current round index. For each stored value it drives the LEDs on for a programmable time, then off for a programmable time. It sits between the game control unit, which starts it and waits for its done pulse, and the datapath, where it owns the memory address and LED mux during playback.

---
 rtl/exp7_mostra_sequencia.sv | 105 ++++++++++
 tb/tb_exp7_mostra_sequencia.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/exp7_mostra_sequencia.sv
// Playback sequencer for the memory game: walks the jogadas memory from
// address 0 up to the captured round index, lighting each stored pattern.
module exp7_mostra_sequencia #(
    parameter int T_ACESO   = 50_000_000,
    parameter int T_APAGADO = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic [3:0] rodada,
    input  logic [3:0] dado_mem,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ativo,
    output logic       fim_mostra,
    output logic [3:0] db_estado
);

    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] CARREGA = 3'd1;
    localparam logic [2:0] ACENDE  = 3'd2;
    localparam logic [2:0] APAGA   = 3'd3;
    localparam logic [2:0] PROXIMO = 3'd4;
    localparam logic [2:0] FINAL   = 3'd5;

    localparam logic [26:0] ACESO_FIM   = 27'(T_ACESO - 1);
    localparam logic [26:0] APAGADO_FIM = 27'(T_APAGADO - 1);

    logic [2:0]  estado;
    logic [3:0]  cont_end;
    logic [3:0]  rodada_reg;
    logic [3:0]  leds_reg;
    logic [26:0] timer;

    // Abort wins over everything; the round index is frozen at the accept edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            cont_end   <= 4'd0;
            rodada_reg <= 4'd0;
            leds_reg   <= 4'd0;
            timer      <= 27'd0;
        end else if (abortar) begin
            estado   <= OCIOSO;
            cont_end <= 4'd0;
            timer    <= 27'd0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        estado     <= CARREGA;
                        cont_end   <= 4'd0;
                        rodada_reg <= rodada;
                    end
                end
                CARREGA: begin
                    leds_reg <= dado_mem;
                    timer    <= 27'd0;
                    estado   <= ACENDE;
                end
                ACENDE: begin
                    if (timer == ACESO_FIM) begin
                        timer  <= 27'd0;
                        estado <= APAGA;
                    end else begin
                        timer <= timer + 27'd1;
                    end
                end
                APAGA: begin
                    if (timer == APAGADO_FIM) begin
                        timer  <= 27'd0;
                        estado <= (cont_end == rodada_reg) ? FINAL : PROXIMO;
                    end else begin
                        timer <= timer + 27'd1;
                    end
                end
                PROXIMO: begin
                    cont_end <= cont_end + 4'd1;
                    estado   <= CARREGA;
                end
                FINAL: begin
                    estado <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign endereco   = cont_end;
    assign leds       = (estado == ACENDE) ? leds_reg : 4'd0;
    assign ativo      = (estado != OCIOSO);
    assign fim_mostra = (estado == FINAL);

    always_comb begin
        db_estado = 4'hF;
        case (estado)
            OCIOSO, CARREGA, ACENDE, APAGA, PROXIMO, FINAL: db_estado = {1'b0, estado};
            default: db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_exp7_mostra_sequencia.sv
// Bench for exp7_mostra_sequencia: per-cycle output trace predicted from the
// show rules (element timing, memory contents) and compared every cycle.
module tb_exp7_mostra_sequencia;

    localparam int T_ON  = 2;
    localparam int T_OFF = 1;

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] endereco;
        logic [3:0] db;
        logic       ativo;
        logic       fim;
    } snap_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic [3:0] rodada;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ativo;
    logic       fim_mostra;
    logic [3:0] db_estado;

    logic [3:0] mem [16];
    snap_t      exp_q [$];
    snap_t      obs;
    int         compared   = 0;
    int         mismatched = 0;

    exp7_mostra_sequencia #(.T_ACESO(T_ON), .T_APAGADO(T_OFF)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .abortar    (abortar),
        .rodada     (rodada),
        .dado_mem   (dado_mem),
        .endereco   (endereco),
        .leds       (leds),
        .ativo      (ativo),
        .fim_mostra (fim_mostra),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    assign dado_mem = mem[endereco];
    assign obs = '{leds: leds, endereco: endereco, db: db_estado, ativo: ativo, fim: fim_mostra};

    // Whole show as a list of cycles: carrega, T_ON lit, T_OFF dark, proximo between elements
    task automatic build_expected(input int r);
        exp_q.delete();
        for (int i = 0; i <= r; i++) begin
            exp_q.push_back('{leds: 4'd0, endereco: i[3:0], db: 4'd1, ativo: 1'b1, fim: 1'b0});
            for (int t = 0; t < T_ON; t++)
                exp_q.push_back('{leds: mem[i], endereco: i[3:0], db: 4'd2, ativo: 1'b1, fim: 1'b0});
            for (int t = 0; t < T_OFF; t++)
                exp_q.push_back('{leds: 4'd0, endereco: i[3:0], db: 4'd3, ativo: 1'b1, fim: 1'b0});
            if (i < r)
                exp_q.push_back('{leds: 4'd0, endereco: i[3:0], db: 4'd4, ativo: 1'b1, fim: 1'b0});
        end
        exp_q.push_back('{leds: 4'd0, endereco: r[3:0], db: 4'd5, ativo: 1'b1, fim: 1'b1});
        exp_q.push_back('{leds: 4'd0, endereco: r[3:0], db: 4'd0, ativo: 1'b0, fim: 1'b0});
    endtask

    task automatic check_output(input string tag, input int cyc, input snap_t expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s cycle %0d: observed leds=%h end=%h db=%h ativo=%b fim=%b, expected leds=%h end=%h db=%h ativo=%b fim=%b",
                   tag, cyc, obs.leds, obs.endereco, obs.db, obs.ativo, obs.fim,
                   expv.leds, expv.endereco, expv.db, expv.ativo, expv.fim);
        end
    endtask

    task automatic fill_random_mem();
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
    endtask

    // mode 0: plain show; 1: iniciar/rodada disturbed mid-show;
    // 2: abort in second element's acende; 3: async reset in second element's apaga
    task automatic apply_stimulus(input int r, input int mode, input string tag);
        build_expected(r);
        iniciar = 1'b1;
        rodada  = r[3:0];
        @(posedge clock);
        #1 iniciar = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            check_output(tag, k + 1, exp_q[k]);
            if (mode == 1) begin
                if (k == 2 || k == 7) begin
                    iniciar = 1'b1;
                    rodada  = 4'd7;
                end else if (k == 3 || k == 8) begin
                    iniciar = 1'b0;
                end
            end
            if (mode == 2 && exp_q[k].db == 4'd2 && exp_q[k].endereco == 4'd1) begin
                abortar = 1'b1;
                @(negedge clock);
                check_output({tag, "_after_abort"}, k + 2, '0);
                abortar = 1'b0;
                return;
            end
            if (mode == 3 && exp_q[k].db == 4'd3 && exp_q[k].endereco == 4'd1) begin
                #2 reset = 1'b1;
                #1 check_output({tag, "_async_reset"}, k + 1, '0);
                @(negedge clock);
                check_output({tag, "_reset_held"}, k + 2, '0);
                reset = 1'b0;
                return;
            end
        end
        rodada = 4'd0;
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        abortar = 1'b0;
        rodada  = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;

        #2 check_output("reset_state", 0, '0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_output("idle_after_reset", 0, '0);

        $display("[TB] two-element show");
        mem[0] = 4'd3;
        mem[1] = 4'd9;
        apply_stimulus(1, 0, "two_elem");

        $display("[TB] single-element show");
        mem[0] = 4'd5;
        apply_stimulus(0, 0, "single_elem");

        $display("[TB] sixteen distinct patterns");
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            automatic int j = $urandom_range(i, 0);
            automatic logic [3:0] tmp = mem[i];
            mem[i] = mem[j];
            mem[j] = tmp;
        end
        apply_stimulus(15, 0, "full_16");

        $display("[TB] random shows");
        for (int n = 0; n < 3; n++) begin
            fill_random_mem();
            apply_stimulus($urandom_range(15, 0), 0, "random_show");
        end

        $display("[TB] abort mid-show");
        fill_random_mem();
        apply_stimulus(3, 2, "abort");
        iniciar = 1'b1;
        abortar = 1'b1;
        rodada  = 4'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_output("iniciar_and_abortar", k + 1, '0);
        end
        iniciar = 1'b0;
        abortar = 1'b0;

        $display("[TB] iniciar/rodada ignored mid-show");
        fill_random_mem();
        apply_stimulus(1, 1, "disturbed");
        @(negedge clock);
        check_output("idle_after_disturbed", 0, '{leds: 4'd0, endereco: 4'd1, db: 4'd0, ativo: 1'b0, fim: 1'b0});

        $display("[TB] async reset in apaga, then restart");
        fill_random_mem();
        apply_stimulus(2, 3, "reset_mid");
        apply_stimulus(2, 0, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
